// File: rtl/image_window_3x3.sv
// 3x3 sliding-window generator: bursts image rows out of the upstream row FIFO,
// keeps the two previous rows in line buffers and emits one window per column.
// Optional stride-2 output decimation is enabled with `define IMAGE_WIN_STRIDE2_EN.
module image_window_3x3 #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   col_num,
  input  logic [ADDR_BITS:0]   row_num,
  output logic [ADDR_BITS:0]   fifo_count,
  input  logic                 fifo_ready,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 win_valid,
  output logic [9*WIDTH-1:0]   win_data,
  output logic                 busy,
  output logic                 done
);

  localparam int CW    = ADDR_BITS + 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [CW-1:0] MIN_DIM  = CW'(3);
  localparam logic [CW-1:0] MAX_COLS = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_GUARD,
    S_DRAIN
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]          r_cols, r_rows, r_col, r_row, r_fifo_count;
  logic                   r_guard_cnt;
  logic [ADDR_BITS-1:0]   r_wr_addr;
  logic                   r_p1_valid, r_p2_valid, r_p1_win, r_win_valid;
  logic [8:0][WIDTH-1:0]  r_win_data;

  logic [WIDTH-1:0]       r_lb0 [DEPTH];
  logic [WIDTH-1:0]       r_lb1 [DEPTH];
  logic [WIDTH-1:0]       r_lb0_q, r_lb1_q;
  logic [2:0][WIDTH-1:0]  r_hcol0, r_hcol1;

  logic                   w_accept, w_last_col, w_last_row, w_hit, w_stride_ok;
  logic [2:0][WIDTH-1:0]  w_new_col;
  logic [8:0][WIDTH-1:0]  w_win;

  assign w_accept = start && (r_state == S_IDLE) &&
                    (col_num >= MIN_DIM) && (row_num >= MIN_DIM) &&
                    (col_num <= MAX_COLS);

  assign w_last_col = (r_col == r_cols - ONE);
  assign w_last_row = (r_row == r_rows - ONE);

`ifdef IMAGE_WIN_STRIDE2_EN
  // r-2 and c-2 even is the same as r and c even.
  assign w_stride_ok = ~r_row[0] & ~r_col[0];
`else
  assign w_stride_ok = 1'b1;
`endif

  // Window flag is decided at read time from the read's own (row, col).
  assign w_hit = fifo_rd_en && (r_row >= TWO) && (r_col >= TWO) && w_stride_ok;

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    fifo_rd_en = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (fifo_ready) w_next = S_READ;
      S_READ: begin
        fifo_rd_en = 1'b1;
        if (w_last_col) w_next = w_last_row ? S_DRAIN : S_GUARD;
      end
      S_GUARD: if (r_guard_cnt) w_next = S_WAIT;
      S_DRAIN: begin
        if (!r_p1_valid && !r_p2_valid) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy       = (r_state != S_IDLE);
  assign fifo_count = r_fifo_count;
  assign win_valid  = r_win_valid;
  assign win_data   = r_win_data;

  // Column vector index 0 is the top (oldest) row.
  assign w_new_col = {fifo_dout, r_lb0_q, r_lb1_q};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win[3*i]   = r_hcol0[i];
      w_win[3*i+1] = r_hcol1[i];
      w_win[3*i+2] = w_new_col[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cols       <= '0;
      r_rows       <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_fifo_count <= '0;
      r_guard_cnt  <= 1'b0;
      r_wr_addr    <= '0;
      r_p1_valid   <= 1'b0;
      r_p2_valid   <= 1'b0;
      r_p1_win     <= 1'b0;
      r_win_valid  <= 1'b0;
      r_win_data   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cols       <= col_num;
        r_rows       <= row_num;
        r_fifo_count <= col_num;
        r_col        <= '0;
        r_row        <= '0;
      end
      if (fifo_rd_en) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + ONE;
        end else begin
          r_col <= r_col + ONE;
        end
      end
      r_guard_cnt <= (r_state == S_GUARD) ? ~r_guard_cnt : 1'b0;
      r_wr_addr   <= r_col[ADDR_BITS-1:0];
      r_p1_valid  <= fifo_rd_en;
      r_p2_valid  <= r_p1_valid;
      r_p1_win    <= w_hit;
      r_win_valid <= r_p1_win;
      if (r_p1_valid) r_win_data <= w_win;
    end
  end

  // NOTE: line-buffer RAM and its read/shift registers carry no reset so they map onto block RAM;
  // stale contents are never emitted because the first two rows and columns raise no valid.
  always_ff @(posedge clk) begin
    if (fifo_rd_en) begin
      r_lb1_q <= r_lb1[r_col[ADDR_BITS-1:0]];
      r_lb0_q <= r_lb0[r_col[ADDR_BITS-1:0]];
    end
    if (r_p1_valid) begin
      r_lb1[r_wr_addr] <= r_lb0_q;
      r_lb0[r_wr_addr] <= fifo_dout;
      r_hcol0          <= r_hcol1;
      r_hcol1          <= w_new_col;
    end
  end

endmodule

// File: tb/tb_image_window_3x3.sv
// Scoreboard bench for image_window_3x3: a FIFO model serves pixel r*16+c,
// expected windows are queued at stimulus time and a monitor compares on win_valid.
module tb_image_window_3x3;

  localparam int W  = 8;
  localparam int AB = 10;
  localparam int CW = AB + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   col_num, row_num, fifo_count;
  logic            fifo_ready = 1'b1;
  logic            fifo_rd_en;
  logic [W-1:0]    fifo_dout = '0;
  logic            win_valid;
  logic [9*W-1:0]  win_data;
  logic            busy, done;

  always #5 clk = ~clk;

  image_window_3x3 #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .col_num    (col_num),
    .row_num    (row_num),
    .fifo_count (fifo_count),
    .fifo_ready (fifo_ready),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .busy       (busy),
    .done       (done)
  );

  int checks   = 0;
  int failures = 0;
  logic [71:0] exp_q[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 16 + c) & 255);
  endfunction

  function automatic logic [71:0] window(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = pix(r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic push_image(input int rows, input int cols);
    for (int r = 2; r < rows; r++)
      for (int c = 2; c < cols; c++) begin
`ifdef IMAGE_WIN_STRIDE2_EN
        if (((r - 2) % 2 == 0) && ((c - 2) % 2 == 0)) exp_q.push_back(window(r, c));
`else
        exp_q.push_back(window(r, c));
`endif
      end
  endtask

  // Hand-computed windows of the 4x4 image (k8 in the top byte).
  task automatic push_hand_4x4();
    exp_q.push_back(72'h22_21_20_12_11_10_02_01_00);
`ifndef IMAGE_WIN_STRIDE2_EN
    exp_q.push_back(72'h23_22_21_13_12_11_03_02_01);
    exp_q.push_back(72'h32_31_30_22_21_20_12_11_10);
    exp_q.push_back(72'h33_32_31_23_22_21_13_12_11);
`endif
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // FIFO model: data for a read in cycle t appears early in cycle t+1.
  int m_cols = 1;
  int m_idx  = 0;
  always begin : fifo_model
    logic rd;
    @(negedge clk);
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd) begin
      fifo_dout = pix(m_idx / m_cols, m_idx % m_cols);
      m_idx++;
    end
  end

  // Read-burst monitor and fifo_ready stall generator.
  int rd_run = 0, burst_end_cyc = 0, img_bursts = 0, total_reads = 0;
  int stall_cnt = 0, rd_in_stall = 0, exp_cols = 4;
  bit stall_mode = 1'b0, chk_en = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      rd_run = 0;
    end else begin
      if (stall_cnt > 0) begin
        if (fifo_rd_en) rd_in_stall++;
        stall_cnt--;
      end
      if (fifo_rd_en) begin
        // 2 GUARD cycles plus the WAIT cycle separate consecutive row bursts.
        if (rd_run == 0 && img_bursts > 0 && chk_en && !stall_mode)
          check("guard_gap", cyc - burst_end_cyc, 3);
        rd_run++;
        total_reads++;
      end else if (rd_run != 0) begin
        if (chk_en) check("burst_len", rd_run, exp_cols);
        rd_run        = 0;
        burst_end_cyc = cyc;
        img_bursts++;
        if (stall_mode) stall_cnt = 10;
      end
    end
    fifo_ready = (stall_cnt == 0);
  end

  // Window scoreboard monitor.
  int vrun = 0, last_valid_cyc = -10, done_cnt = 0;
  always @(negedge clk) begin
    logic [71:0] e;
    if (rst) begin
      vrun = 0;
    end else begin
      if (win_valid) begin
        if (exp_q.size() == 0) begin
          check("window_expected", 1'b0, 1'b1);
        end else begin
          e = exp_q.pop_front();
          check("window", win_data, e);
        end
        vrun++;
        last_valid_cyc = cyc;
      end else if (vrun != 0) begin
`ifndef IMAGE_WIN_STRIDE2_EN
        if (chk_en) check("valid_run", vrun, exp_cols - 2);
`endif
        vrun = 0;
      end
      if (done) begin
        done_cnt++;
`ifndef IMAGE_WIN_STRIDE2_EN
        check("done_latency", cyc - last_valid_cyc, 1);
`endif
      end
    end
  end

  task automatic run_image(input int rows, input int cols, input bit stall, input bit poke);
    int d0, n;
    exp_cols   = cols;
    m_cols     = cols;
    m_idx      = 0;
    img_bursts = 0;
    chk_en     = 1'b1;
    d0         = done_cnt;
    if (stall) begin
      stall_mode  = 1'b1;
      rd_in_stall = 0;
      stall_cnt   = 10;
    end
    @(negedge clk);
    start   = 1'b1;
    col_num = CW'(cols);
    row_num = CW'(rows);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("fifo_count", fifo_count, 72'(cols));
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (poke && n == 12) begin
        start   = 1'b1;
        col_num = CW'(5);
        row_num = CW'(5);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", done_cnt - d0, 1);
    repeat (2) @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    check("row_bursts", img_bursts, rows);
    check("fifo_count_hold", fifo_count, 72'(cols));
    if (stall) begin
      check("reads_during_stall", rd_in_stall, 0);
      stall_mode = 1'b0;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic try_ignored(input int cols, input int rows);
    int  r0;
    bit  busy_seen;
    r0 = total_reads;
    busy_seen = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    col_num = CW'(cols);
    row_num = CW'(rows);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      busy_seen |= busy;
      @(negedge clk);
    end
    check("ignored_busy", busy_seen, 1'b0);
    check("ignored_reads", total_reads - r0, 0);
  endtask

  task automatic reset_abort();
    int  r0, n, d0;
    bit  busy_seen;
    exp_cols   = 8;
    m_cols     = 8;
    m_idx      = 0;
    img_bursts = 0;
    chk_en     = 1'b0;
    push_image(8, 8);
    r0 = total_reads;
    @(negedge clk);
    start   = 1'b1;
    col_num = CW'(8);
    row_num = CW'(8);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((total_reads - r0) < 27 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_row3", (total_reads - r0) >= 27, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_win_valid", win_valid, 1'b0);
    check("abort_rd_en", fifo_rd_en, 1'b0);
    check("abort_win_data", win_data, 72'h0);
    check("abort_fifo_count", fifo_count, 72'h0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stays_idle", busy_seen, 1'b0);
    exp_q.delete();
    chk_en = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    col_num = '0;
    row_num = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_win_valid", win_valid, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_fifo_count", fifo_count, 72'h0);
    check("rst_win_data", win_data, 72'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    push_hand_4x4();
    run_image(4, 4, 1'b0, 1'b1);

    push_image(5, 6);
    run_image(5, 6, 1'b1, 1'b0);

    try_ignored(2, 4);
    try_ignored(4, 2);
    try_ignored(1025, 4);

    reset_abort();

    push_hand_4x4();
    run_image(4, 4, 1'b0, 1'b0);

    push_image(6, 6);
    run_image(6, 6, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_window_3x3.md
Name: image_window_3x3

Overview:
- Downstream consumer of the nine-pixel row FIFO stage.
- Waits until the FIFO reports that a full image row is buffered, then bursts that row out of the FIFO.
- Keeps the two previous rows in internal line buffers and emits a 3x3 pixel window per column position, with no padding.
- Feeds the convolution datapath.

Parameters:
- WIDTH, 8: pixel width in bits.
- ADDR_BITS, 10: line-buffer address width. Maximum row length is 2^ADDR_BITS pixels.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; launches processing of one image
- col_num  input  ADDR_BITS+1  pixels per row; sampled on accepted start
- row_num  input  ADDR_BITS+1  rows per image; sampled on accepted start
- fifo_count  output  ADDR_BITS+1  row length requested from the FIFO (drives its M_count)
- fifo_ready  input  1  FIFO M_Ready: at least fifo_count pixels are buffered
- fifo_rd_en  output  1  FIFO read enable
- fifo_dout  input  WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en
- win_valid  output  1  win_data valid this cycle
- win_data  output  9*WIDTH  window; element k=3*i+j (i=row, 0=top; j=col, 0=left/oldest) at bits [WIDTH*(k+1)-1:WIDTH*k]
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last window

Behaviour:
- Reset values: fifo_rd_en=0, win_valid=0, win_data=0, done=0, busy=0, fifo_count=0, FSM=IDLE. Line-buffer RAM contents are not cleared. A reset mid-image aborts to IDLE with no done pulse.
- start is accepted only in IDLE with col_num>=3, row_num>=3 and col_num<=2^ADDR_BITS. Otherwise it is ignored and the block stays IDLE.
- start while busy is ignored.
- On accept: latch col_num/row_num, set fifo_count=col_num, clear row/col counters, set busy=1.
- FSM states:
  - IDLE -> WAIT on an accepted start.
  - WAIT -> READ when fifo_ready=1.
  - READ: fifo_rd_en=1 for exactly col_num consecutive cycles, col address c=0..col_num-1. After the last read -> GUARD, or -> DRAIN if this was the last row.
  - GUARD: 2 cycles, fifo_ready ignored, to cover the FIFO's registered M_Ready lag. Then -> WAIT.
  - DRAIN: wait for the pipeline to empty, pulse done, -> IDLE with busy=0.
- Pipeline, for rd_en at cycle t on column c:
  - t: issue synchronous line-buffer reads LB1[c] and LB0[c].
  - t+1: fifo_dout, LB1 data and LB0 data are valid. Column vector is (top=LB1[c], mid=LB0[c], bot=fifo_dout). Write LB1[c]<=LB0[c] and LB0[c]<=fifo_dout.
  - Shift the column vector into a 3-column horizontal register.
  - t+2: registered win_data/win_valid.
- Same-address read/write never collides: the write to c at t+1 coincides with the read of c+1.
- win_valid=1 exactly when row index r>=2 and column index c>=2, where (r,c) is the bottom-right pixel.
  - Windows per image: (row_num-2)*(col_num-2).
  - Within a row, valids are contiguous (col_num-2 cycles).
- The horizontal register is not cleared between rows. The first two columns of each row produce no valid, so stale data is never emitted.
- done pulses the cycle after the last win_valid.
- fifo_count holds its value until the next accepted start.
- Counters are ADDR_BITS+1 wide; no wrap-around within legal sizes.

Optional Feature:
- Macro: IMAGE_WIN_STRIDE2_EN.
- Defined: win_valid is asserted only when (r-2) and (c-2) are both even, giving stride-2 windows. Window count is ceil((row_num-2)/2)*ceil((col_num-2)/2). Read and FIFO behaviour are unchanged.
- Undefined: stride 1 as described under Behaviour.

Test Plan:
- 4x4 image, pixel=r*16+c, fifo_ready held 1 -> 4 windows:
  - first window elements k0..k8 = 00,01,02,10,11,12,20,21,22 (hex);
  - last window center=0x22, bottom-right=0x33;
  - 2 consecutive valids per row;
  - done 1 cycle after the 4th valid; fifo_count=4.
- 5x6 image with fifo_ready held 0 for 10 cycles before each row -> fifo_rd_en stays 0 during the stall, then exactly 6 consecutive reads per row; 12 windows, all matching the golden model.
- fifo_ready held 1 continuously -> each row is separated by exactly 2 GUARD cycles with fifo_rd_en=0.
- start with col_num=2 -> ignored: busy stays 0, no fifo_rd_en. start pulsed mid-image -> no effect on the window sequence.
- rst asserted during row 3 of an 8x8 image -> next cycle all outputs 0, busy=0, no done. A new 4x4 image afterwards yields correct windows.
- With IMAGE_WIN_STRIDE2_EN, 6x6 image -> 4 windows, top-left pixels 00,02,20,22.
